// File: rtl/hex_pkg.sv
// Shared types, codes and FSM state encoding for the hex syscall unit.
package hex_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned WADDR_WIDTH   = 16;
  localparam int unsigned STREAM_WIDTH  = 2;
  localparam int unsigned SYSCALL_WIDTH = 8;
  localparam int unsigned BYTE_WIDTH    = 8;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [WADDR_WIDTH-1:0]   waddr_t;
  typedef logic [STREAM_WIDTH-1:0]  stream_t;
  typedef logic [SYSCALL_WIDTH-1:0] syscall_t;
  typedef logic [BYTE_WIDTH-1:0]    byte_t;

  localparam syscall_t SYS_EXIT  = SYSCALL_WIDTH'(0);
  localparam syscall_t SYS_WRITE = SYSCALL_WIDTH'(1);
  localparam syscall_t SYS_READ  = SYSCALL_WIDTH'(2);

  localparam waddr_t SP_ADDR = WADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SP,
    ST_RD_ARG0,
    ST_RD_ARG1,
    ST_OUT_WAIT,
    ST_IN_WAIT,
    ST_WR_RES,
    ST_EXIT,
    ST_HALTED,
    ST_DONE
  } syscall_state_t;

  typedef struct packed {
    logic   valid;
    logic   we;
    waddr_t addr;
    data_t  data;
  } mem_req_t;

  // Stack-relative address; wraps at the top of the word space.
  function automatic waddr_t sp_plus(input waddr_t sp, input waddr_t k);
    return waddr_t'(sp + k);
  endfunction

endpackage

// File: rtl/hex_syscall_unit_if.sv
// Core, data-memory and byte-stream signals of the syscall unit.
interface hex_syscall_unit_if;
  import hex_pkg::*;

  logic     i_syscall_valid;
  syscall_t i_syscall;
  logic     o_busy;

  logic     o_m_valid;
  logic     o_m_we;
  waddr_t   o_m_addr;
  data_t    o_m_data;
  data_t    i_m_data;

  logic     o_out_valid;
  logic     i_out_ready;
  byte_t    o_out_data;
  stream_t  o_out_stream;

  logic     o_in_ready;
  logic     i_in_valid;
  byte_t    i_in_data;
  stream_t  o_in_stream;

  logic     o_exit_valid;
  data_t    o_exit_code;
  logic     o_bad_syscall;

  modport master (
    input  i_syscall_valid, i_syscall, i_m_data, i_out_ready, i_in_valid, i_in_data,
    output o_busy, o_m_valid, o_m_we, o_m_addr, o_m_data,
    output o_out_valid, o_out_data, o_out_stream,
    output o_in_ready, o_in_stream, o_exit_valid, o_exit_code, o_bad_syscall
  );

  modport slave (
    output i_syscall_valid, i_syscall, i_m_data, i_out_ready, i_in_valid, i_in_data,
    input  o_busy, o_m_valid, o_m_we, o_m_addr, o_m_data,
    input  o_out_valid, o_out_data, o_out_stream,
    input  o_in_ready, o_in_stream, o_exit_valid, o_exit_code, o_bad_syscall
  );

endinterface

// File: rtl/hex_syscall_unit.sv
// Syscall service unit: stalls the core, fetches SP and arguments from memory,
// runs EXIT/WRITE/READ against the byte streams and writes back READ results.
module hex_syscall_unit
  import hex_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst,
  hex_syscall_unit_if.master bus
);

  syscall_state_t state, state_nxt;

  syscall_t code_q;
  waddr_t   sp_q;
  byte_t    arg0_q;
  stream_t  arg1_q;
  byte_t    byte_q;
  data_t    exit_code_q;

  mem_req_t req;
  logic     busy;
  logic     out_valid;
  logic     in_ready;
  logic     exit_valid;
  logic     bad;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers, loaded as each memory word or input byte arrives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      code_q      <= '0;
      sp_q        <= '0;
      arg0_q      <= '0;
      arg1_q      <= '0;
      byte_q      <= '0;
      exit_code_q <= '0;
    end else begin
      case (state)
        ST_IDLE:    if (bus.i_syscall_valid) code_q <= bus.i_syscall;
        ST_RD_SP:   sp_q <= bus.i_m_data[WADDR_WIDTH-1:0];
        ST_RD_ARG0: begin
          arg0_q <= bus.i_m_data[BYTE_WIDTH-1:0];
          // Exit code is live during the exit pulse and held until reset
          if (code_q == SYS_EXIT) exit_code_q <= bus.i_m_data;
        end
        ST_RD_ARG1: arg1_q <= bus.i_m_data[STREAM_WIDTH-1:0];
        ST_IN_WAIT: if (bus.i_in_valid) byte_q <= bus.i_in_data;
        default: ;
      endcase
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    req        = '0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    exit_valid = 1'b0;
    bad        = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = bus.i_syscall_valid;
        if (bus.i_syscall_valid) begin
          req.valid = 1'b1;
          req.addr  = SP_ADDR;
          state_nxt = ST_RD_SP;
        end
      end
      ST_RD_SP: begin
        req.valid = 1'b1;
        req.addr  = sp_plus(bus.i_m_data[WADDR_WIDTH-1:0], WADDR_WIDTH'(2));
        state_nxt = ST_RD_ARG0;
      end
      ST_RD_ARG0: begin
        case (code_q)
          SYS_EXIT:  state_nxt = ST_EXIT;
          SYS_WRITE: begin
            req.valid = 1'b1;
            req.addr  = sp_plus(sp_q, WADDR_WIDTH'(3));
            state_nxt = ST_RD_ARG1;
          end
          SYS_READ:  state_nxt = ST_IN_WAIT;
          default: begin
            bad       = 1'b1;
            state_nxt = ST_DONE;
          end
        endcase
      end
      ST_RD_ARG1: state_nxt = ST_OUT_WAIT;
      ST_OUT_WAIT: begin
        out_valid = 1'b1;
        if (bus.i_out_ready) state_nxt = ST_DONE;
      end
      ST_IN_WAIT: begin
        in_ready = 1'b1;
        if (bus.i_in_valid) state_nxt = ST_WR_RES;
      end
      ST_WR_RES: begin
        req.valid = 1'b1;
        req.we    = 1'b1;
        req.addr  = sp_plus(sp_q, WADDR_WIDTH'(1));
        req.data  = DATA_WIDTH'(byte_q);
        state_nxt = ST_DONE;
      end
      ST_EXIT: begin
        exit_valid = 1'b1;
        state_nxt  = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      ST_DONE: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.o_busy        = busy;
  assign bus.o_m_valid     = req.valid;
  assign bus.o_m_we        = req.we;
  assign bus.o_m_addr      = req.addr;
  assign bus.o_m_data      = req.data;
  assign bus.o_out_valid   = out_valid;
  assign bus.o_out_data    = out_valid ? arg0_q : '0;
  assign bus.o_out_stream  = out_valid ? arg1_q : '0;
  assign bus.o_in_ready    = in_ready;
  assign bus.o_in_stream   = in_ready ? arg0_q[STREAM_WIDTH-1:0] : '0;
  assign bus.o_exit_valid  = exit_valid;
  assign bus.o_exit_code   = exit_code_q;
  assign bus.o_bad_syscall = bad;

endmodule

// File: tb/tb_hex_syscall_unit.sv
// Randomised bench for hex_syscall_unit with a transaction-level expectation model.
module tb_hex_syscall_unit;
  import hex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_syscall_unit_if bus();
  hex_syscall_unit dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  data_t mem [0:65535];

  typedef struct packed {
    logic   we;
    waddr_t addr;
    data_t  data;
  } obs_req_t;

  obs_req_t           obs_req[$];
  logic [9:0]         obs_out[$];
  logic [9:0]         obs_in[$];
  int                 obs_exit = 0;
  data_t              obs_exit_code = '0;
  int                 obs_bad = 0;
  logic               prev_hold = 1'b0;
  byte_t              prev_data = '0;
  stream_t            prev_stream = '0;
  int                 last_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data memory: one-cycle read latency, junk on the bus when nothing was read
  always @(posedge clk) begin
    if (bus.o_m_valid && bus.o_m_we) mem[bus.o_m_addr] <= bus.o_m_data;
    bus.i_m_data <= (bus.o_m_valid && !bus.o_m_we) ? mem[bus.o_m_addr] : data_t'($urandom);
  end

  // Per-cycle output checks and event capture
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.o_m_valid) obs_req.push_back({bus.o_m_we, bus.o_m_addr, bus.o_m_data});
      else chk("mem_idle_zero", 64'({bus.o_m_we, bus.o_m_addr, bus.o_m_data}), 64'd0);
      if (prev_hold)
        chk("out_hold", 64'({bus.o_out_valid, bus.o_out_data, bus.o_out_stream}),
            64'({1'b1, prev_data, prev_stream}));
      if (!bus.o_out_valid) chk("out_idle_zero", 64'({bus.o_out_data, bus.o_out_stream}), 64'd0);
      else if (bus.i_out_ready) obs_out.push_back({bus.o_out_data, bus.o_out_stream});
      if (!bus.o_in_ready) chk("in_idle_zero", 64'(bus.o_in_stream), 64'd0);
      else if (bus.i_in_valid) obs_in.push_back({bus.o_in_stream, bus.i_in_data});
      if (bus.o_exit_valid) begin
        obs_exit++;
        obs_exit_code = bus.o_exit_code;
      end
      if (bus.o_bad_syscall) obs_bad++;
    end
    prev_hold   = !rst && bus.o_out_valid && !bus.i_out_ready;
    prev_data   = bus.o_out_data;
    prev_stream = bus.o_out_stream;
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 64'({bus.o_busy, bus.o_m_valid, bus.o_m_we, bus.o_out_valid, bus.o_in_ready,
                            bus.o_exit_valid, bus.o_bad_syscall, bus.o_out_data, bus.o_out_stream,
                            bus.o_in_stream, bus.o_m_addr}), 64'd0);
    chk({name, "_data"}, 64'({bus.o_m_data, bus.o_exit_code}), 64'd0);
  endtask

  // Presents one SVC, plays the stream partner with the given delay, counts stalled cycles
  task automatic run_call(input syscall_t c, input int dly, input byte_t b, input int max_cyc,
                          output int busy_cnt, output logic timed_out);
    int w;
    w = 0;
    busy_cnt = 0;
    timed_out = 1'b1;
    @(negedge clk);
    bus.i_syscall_valid = 1'b1;
    bus.i_syscall = c;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.o_out_valid) begin
        bus.i_out_ready = (w >= dly);
        w++;
      end else bus.i_out_ready = 1'($urandom_range(0, 1));
      if (bus.o_in_ready) begin
        bus.i_in_valid = (w >= dly);
        bus.i_in_data  = (w >= dly) ? b : byte_t'($urandom);
        w++;
      end else begin
        bus.i_in_valid = 1'($urandom_range(0, 1));
        bus.i_in_data  = byte_t'($urandom);
      end
      #1;
      if (bus.o_busy) busy_cnt++;
      else begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.i_syscall_valid = 1'b0;
    bus.i_out_ready = 1'b0;
    bus.i_in_valid = 1'b0;
  endtask

  // Expected outcome derived from memory contents and the syscall rules, then compared
  task automatic do_call(input syscall_t c, input int dly, input byte_t b);
    waddr_t sp;
    data_t  a0, a1;
    int     exp_busy, busy_cnt;
    logic   to;
    logic [WADDR_WIDTH:0] exp_req[$];
    sp = mem[SP_ADDR][WADDR_WIDTH-1:0];
    a0 = mem[waddr_t'(sp + 16'd2)];
    a1 = mem[waddr_t'(sp + 16'd3)];
    exp_req.delete();
    exp_req.push_back({1'b0, SP_ADDR});
    exp_req.push_back({1'b0, waddr_t'(sp + 16'd2)});
    if (c == SYS_WRITE) begin
      exp_req.push_back({1'b0, waddr_t'(sp + 16'd3)});
      exp_busy = 5 + dly;
    end else if (c == SYS_READ) begin
      exp_req.push_back({1'b1, waddr_t'(sp + 16'd1)});
      exp_busy = 5 + dly;
    end else if (c == SYS_EXIT) exp_busy = 12;
    else exp_busy = 3;
    obs_req.delete(); obs_out.delete(); obs_in.delete();
    obs_exit = 0; obs_bad = 0;
    run_call(c, dly, b, (c == SYS_EXIT) ? 12 : 200, busy_cnt, to);
    #3;
    last_busy = busy_cnt;
    chk("timeout", 64'(to), 64'(c == SYS_EXIT));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("req_count", 64'(obs_req.size()), 64'(exp_req.size()));
    for (int i = 0; i < obs_req.size() && i < exp_req.size(); i++) begin
      chk("req_addr", 64'({obs_req[i].we, obs_req[i].addr}), 64'(exp_req[i]));
      if (obs_req[i].we) chk("req_wdata", 64'(obs_req[i].data), 64'(b));
    end
    chk("bad_pulses", 64'(obs_bad), 64'((c > SYS_READ) ? 1 : 0));
    chk("exit_pulses", 64'(obs_exit), 64'((c == SYS_EXIT) ? 1 : 0));
    if (c == SYS_WRITE) begin
      chk("out_count", 64'(obs_out.size()), 64'd1);
      if (obs_out.size() > 0) chk("out_byte", 64'(obs_out[0]), 64'({a0[7:0], a1[1:0]}));
    end else chk("out_count", 64'(obs_out.size()), 64'd0);
    if (c == SYS_READ) begin
      chk("in_count", 64'(obs_in.size()), 64'd1);
      if (obs_in.size() > 0) chk("in_stream", 64'(obs_in[0]), 64'({a0[1:0], b}));
      chk("mem_result", 64'(mem[waddr_t'(sp + 16'd1)]), 64'(b));
    end
    if (c == SYS_EXIT) begin
      chk("exit_code", 64'(obs_exit_code), 64'(a0));
      chk("exit_held", 64'(bus.o_exit_code), 64'(a0));
      chk("halted_busy", 64'(bus.o_busy), 64'd1);
    end else chk("idle_after", 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    int r, dly;
    waddr_t sp;
    logic reached;
    bus.i_syscall_valid = 1'b0;
    bus.i_syscall = '0;
    bus.i_out_ready = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data = '0;
    for (int i = 0; i < 65536; i++) mem[i] = data_t'($urandom);
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // WRITE with three cycles of backpressure
    mem[1] = 32'd100; mem[102] = 32'h41; mem[103] = 32'd1;
    do_call(SYS_WRITE, 3, 8'h00);
    if (obs_out.size() > 0) chk("lit_write_byte", 64'(obs_out[0]), 64'({8'h41, 2'd1}));
    chk("lit_write_busy", 64'(last_busy), 64'd8);

    // READ returning 0x5A after two cycles
    mem[1] = 32'd200; mem[202] = 32'd0;
    do_call(SYS_READ, 2, 8'h5A);
    chk("lit_read_mem", 64'(mem[201]), 64'h5A);

    // Unknown code
    mem[1] = 32'd300;
    do_call(syscall_t'(9), 0, 8'h00);
    chk("lit_bad", 64'(obs_bad), 64'd1);

    // Stack pointer at the top of memory
    mem[1] = 32'h0000_FFFF; mem[2] = 32'h0000_0003;
    do_call(SYS_WRITE, 0, 8'h00);
    if (obs_req.size() > 2) begin
      chk("lit_wrap0", 64'(obs_req[1].addr), 64'h0001);
      chk("lit_wrap1", 64'(obs_req[2].addr), 64'h0002);
    end else chk("lit_wrap_reqs", 64'(obs_req.size()), 64'd3);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      r   = int'($urandom_range(0, 9));
      dly = int'($urandom_range(0, 4));
      sp  = (r == 9) ? waddr_t'($urandom_range(16'hFFFC, 16'hFFFF)) : waddr_t'($urandom);
      mem[1] = {16'($urandom), sp};
      if (waddr_t'(sp + 16'd2) != SP_ADDR) mem[waddr_t'(sp + 16'd2)] = data_t'($urandom);
      if (waddr_t'(sp + 16'd3) != SP_ADDR) mem[waddr_t'(sp + 16'd3)] = data_t'($urandom);
      if (r <= 3 || r == 9) do_call(SYS_WRITE, dly, 8'h00);
      else if (r <= 7) do_call(SYS_READ, dly, byte_t'($urandom));
      else do_call(syscall_t'($urandom_range(3, 255)), 0, 8'h00);
    end

    // Reset while waiting for the output consumer
    mem[1] = 32'd50; mem[52] = 32'h33; mem[53] = 32'd2;
    obs_req.delete();
    @(negedge clk);
    bus.i_syscall_valid = 1'b1;
    bus.i_syscall = SYS_WRITE;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk);
      #1;
      reached = bus.o_out_valid;
    end
    chk("reach_out_wait", 64'(reached), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.i_syscall_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("mid_reset");
    rst = 1'b0;
    chk("mid_reset_no_write", 64'(obs_req.size() > 0 ? obs_req[obs_req.size()-1].we : 1'b0), 64'd0);
    do_call(SYS_WRITE, 1, 8'h00);

    // EXIT halts the unit until reset
    mem[1] = 32'd100; mem[102] = 32'd7;
    do_call(SYS_EXIT, 0, 8'h00);
    if (obs_req.size() > 1) begin
      chk("lit_exit_rd0", 64'(obs_req[0].addr), 64'd1);
      chk("lit_exit_rd1", 64'(obs_req[1].addr), 64'd102);
    end else chk("lit_exit_reqs", 64'(obs_req.size()), 64'd2);
    chk("lit_exit_code", 64'(obs_exit_code), 64'd7);
    repeat (3) @(negedge clk);
    #1;
    chk("halted_ignores", 64'({bus.o_busy, bus.o_m_valid}), 64'b10);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("exit_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
